// File: rtl/fifo_share_pkg.sv
// Shared types and defaults for the shared-FIFO controller.
// The optional FIFO flag cross-check is enabled by FIFO_CTRL_STATUS_CHECK_EN.
package fifo_share_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int DEF_NREQ = 4;
    localparam int DEF_MSBD = 3;
    localparam int DEF_LAST = 15;
    localparam int DEF_MSBA = 3;

    // Occupancy must also represent the completely-full count LAST+1.
    function automatic int occ_width(input int msba);
        return msba + 2;
    endfunction

endpackage

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// Round-robin request search starting at ptr; returns a one-hot grant and its index.
// The pointer register itself lives in the parent controller.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  idx,
    output logic                     any
);

    localparam int PW = $clog2(NREQ);

    always_comb begin : search
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!any && req[k]) begin
                gnt[k] = 1'b1;
                idx    = PW'(k);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one push/pop FIFO between NREQ producers and one consumer, with drain (flush) support.
// Optional flag cross-check against the FIFO: define FIFO_CTRL_STATUS_CHECK_EN.
module fifo_share_ctrl
    import fifo_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int MSBD = DEF_MSBD,
    parameter int LAST = DEF_LAST,
    parameter int MSBA = DEF_MSBA
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*(MSBD+1)-1:0] req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     pop_req,
    output logic                     pop_ack,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     fifo_push,
    output logic [MSBD:0]            fifo_data,
    output logic                     fifo_pop,
    input  logic                     fifo_full_in,
    input  logic                     fifo_empty_in,
    output logic [MSBA+1:0]          occ,
    output logic                     full,
    output logic                     empty,
    output logic                     status_err,
    output state_e                   dbg_state
);

    localparam int DW = MSBD + 1;
    localparam int OW = occ_width(MSBA);
    localparam int PW = $clog2(NREQ);
    localparam logic [OW-1:0] OCC_MAX = OW'(LAST + 1);

    state_e          state;
    logic [PW-1:0]   rr_ptr;
    logic            prio;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;
    logic            run, push_cand, pop_cand, conflict, do_push, do_pop, drain;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Handshake: a producer holds req/req_data until the cycle its gnt bit is high;
    // the consumer's pop_req is accepted in the cycle pop_ack is high. Both are
    // combinational and forced low while reset_n is asserted.
    assign full      = (occ == OCC_MAX);
    assign empty     = (occ == '0);
    assign run       = reset_n && (state == ST_RUN);
    assign push_cand = run && arb_any && !full;
    assign pop_cand  = run && pop_req && !empty;
    assign conflict  = push_cand && pop_cand;
    // The FIFO cannot push and pop together, so a conflict goes to whichever side prio names.
    assign do_push   = push_cand && !(conflict && prio);
    assign do_pop    = pop_cand && !(conflict && !prio);
    assign drain     = reset_n && (state == ST_FLUSH) && !empty;

    assign gnt       = do_push ? arb_gnt : '0;
    assign fifo_push = do_push;
    assign pop_ack   = do_pop;
    assign fifo_pop  = do_pop || drain;
    assign dbg_state = state;

    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) fifo_data = req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            rr_ptr     <= '0;
            prio       <= 1'b0;
            occ        <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (fifo_push)     occ <= occ + OW'(1);
            else if (fifo_pop) occ <= occ - OW'(1);
            if (conflict) prio <= !prio;
            if (do_push) rr_ptr <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
            case (state)
                ST_RUN: begin
                    if (flush) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (empty) begin
                        state      <= ST_RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef FIFO_CTRL_STATUS_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_err <= 1'b0;
        end else if ((full != fifo_full_in) || (empty != fifo_empty_in)) begin
            status_err <= 1'b1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = fifo_full_in ^ fifo_empty_in;
    assign status_err   = 1'b0;
`endif

endmodule
